// File: rtl/ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ctrl_pkg
//  Purpose  : Shared definitions for the multi-cycle control sequencer:
//             state encoding, opcode constants, ALU and SP unit operation
//             codes, opcode class enumeration and the control strobe bundle.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package ctrl_pkg;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5,
        S_ERR    = 3'd6
    } state_t;

    localparam logic [5:0] OP_R    = 6'h00;
    localparam logic [5:0] OP_ADDI = 6'h01;
    localparam logic [5:0] OP_LW   = 6'h02;
    localparam logic [5:0] OP_SW   = 6'h03;
    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_JMP  = 6'h05;
    localparam logic [5:0] OP_PUSH = 6'h06;
    localparam logic [5:0] OP_POP  = 6'h07;
    localparam logic [5:0] OP_CALL = 6'h08;
    localparam logic [5:0] OP_RET  = 6'h09;
    localparam logic [5:0] OP_HALT = 6'h3F;

    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;

    localparam logic [3:0] SP_HOLD = 4'd0;
    localparam logic [3:0] SP_INC  = 4'd1;
    localparam logic [3:0] SP_DEC  = 4'd2;

    // Opcode reduced to its instruction class; every opcode outside the
    // table maps to C_ILL.
    typedef enum logic [3:0] {
        C_R    = 4'd0,
        C_ADDI = 4'd1,
        C_LW   = 4'd2,
        C_SW   = 4'd3,
        C_BEQ  = 4'd4,
        C_JMP  = 4'd5,
        C_PUSH = 4'd6,
        C_POP  = 4'd7,
        C_CALL = 4'd8,
        C_RET  = 4'd9,
        C_HALT = 4'd10,
        C_ILL  = 4'd11
    } op_class_t;

    typedef struct packed {
        logic       mem_req;
        logic       ir_write;
        logic       pc_write;
        logic       pc_op;
        logic       branch;
        logic       reg_dst;
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       alu_src;
        logic       a_op2;
        logic       addr_op;
        logic       write_data_op;
        logic       wd_op2;
        logic       sp_write;
        logic       sp_write2;
        logic [3:0] alu_op;
        logic [3:0] sp_op;
        logic       halted;
        logic       err;
    } ctrl_t;

endpackage
`default_nettype wire

// File: rtl/ctrl_decode.sv
`default_nettype none
// ============================================================================
//  Module   : ctrl_decode
//  Purpose  : Combinational strobe decoder. Maps current state, instruction
//             class, latched funct, ALU zero flag and mem_ready onto the full
//             datapath control bundle.
//  Ports    : reset     in  - forces every strobe low while asserted
//             state     in  - current sequencer state
//             op_class  in  - class of the latched opcode
//             funct     in  - latched R-type ALU function
//             zero      in  - ALU zero flag
//             mem_ready in  - memory access completes this cycle
//             ctl       out - control strobe bundle
//  Revision : 1.0 - initial release
// ============================================================================
module ctrl_decode
    import ctrl_pkg::*;
(
    input  logic      reset,
    input  state_t    state,
    input  op_class_t op_class,
    input  logic [3:0] funct,
    input  logic      zero,
    input  logic      mem_ready,
    output ctrl_t     ctl
);

    logic w_stack_op;

    always_comb begin
        ctl        = '0;
        ctl.alu_op = ALU_ADD;
        ctl.sp_op  = SP_HOLD;
        w_stack_op = (op_class == C_PUSH) || (op_class == C_POP) ||
                     (op_class == C_CALL) || (op_class == C_RET);

        if (!reset) begin
            case (state)
                S_FETCH: begin
                    ctl.mem_req = 1'b1;
                    // IR and PC+1 only commit on the cycle the fetch completes.
                    ctl.ir_write = mem_ready;
                    ctl.pc_write = mem_ready;
                end

                S_EXEC: begin
                    case (op_class)
                        C_R:    ctl.alu_op = funct;
                        C_ADDI: ctl.alu_src = 1'b1;
                        C_LW, C_SW: begin
                            ctl.alu_src = 1'b1;
                            ctl.alu_op  = ALU_ADD;
                        end
                        C_BEQ: begin
                            ctl.branch   = 1'b1;
                            ctl.alu_op   = ALU_SUB;
                            ctl.pc_write = zero;
                        end
                        C_JMP: begin
                            ctl.pc_op    = 1'b1;
                            ctl.pc_write = 1'b1;
                        end
                        C_PUSH, C_CALL: begin
                            ctl.a_op2    = 1'b1;
                            ctl.sp_op    = SP_DEC;
                            ctl.sp_write = 1'b1;
                        end
                        C_POP, C_RET: ctl.a_op2 = 1'b1;
                        default: ;
                    endcase
                end

                S_MEM: begin
                    ctl.mem_req = 1'b1;
                    ctl.addr_op = w_stack_op;
                    case (op_class)
                        C_SW, C_PUSH: ctl.mem_write = 1'b1;
                        C_CALL: begin
                            // Return address goes to the stack; the jump
                            // target is committed only once the write lands.
                            ctl.mem_write     = 1'b1;
                            ctl.write_data_op = 1'b1;
                            ctl.pc_op         = 1'b1;
                            ctl.pc_write      = mem_ready;
                        end
                        C_LW, C_POP, C_RET: ctl.mem_read = 1'b1;
                        default: ;
                    endcase
                end

                S_WB: begin
                    case (op_class)
                        C_R: begin
                            ctl.reg_dst   = 1'b1;
                            ctl.reg_write = 1'b1;
                        end
                        C_ADDI: ctl.reg_write = 1'b1;
                        C_LW: begin
                            ctl.reg_write  = 1'b1;
                            ctl.mem_to_reg = 1'b1;
                        end
                        C_POP: begin
                            ctl.reg_write  = 1'b1;
                            ctl.mem_to_reg = 1'b1;
                            ctl.sp_op      = SP_INC;
                            ctl.sp_write2  = 1'b1;
                        end
                        C_RET: begin
                            ctl.sp_op     = SP_INC;
                            ctl.sp_write2 = 1'b1;
                            ctl.pc_op     = 1'b1;
                            ctl.wd_op2    = 1'b1;
                            ctl.pc_write  = 1'b1;
                        end
                        default: ;
                    endcase
                end

                S_HALT:  ctl.halted = 1'b1;
                S_ERR:   ctl.err    = 1'b1;
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/multicycle_ctrl_fsm.sv
`default_nettype none
// ============================================================================
//  Module   : multicycle_ctrl_fsm
//  Purpose  : Multi-cycle control sequencer. Walks FETCH->DECODE->EXEC->MEM->WB
//             per instruction class, latches opcode/funct when the fetch
//             completes, and guards every memory wait with a watchdog.
//  Ports    : clk, reset (async, active-high)
//             opcode/funct  in  - instruction fields, sampled at end of FETCH
//             zero          in  - ALU zero flag
//             mem_ready     in  - memory access complete
//             mem_req .. spOp   - datapath selects and strobes
//             halted, err   out - sticky terminal status
//             state         out - current state (debug)
//  Revision : 1.0 - initial release
// ============================================================================
module multicycle_ctrl_fsm
    import ctrl_pkg::*;
#(
    parameter int OPW     = 6,
    parameter int TIMEOUT = 16
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [OPW-1:0] opcode,
    input  logic [3:0]     funct,
    input  logic           zero,
    input  logic           mem_ready,
    output logic           mem_req,
    output logic           irWrite,
    output logic           pcWrite,
    output logic           pcOp,
    output logic           branch,
    output logic           regDst,
    output logic           regWrite,
    output logic           memRead,
    output logic           memWrite,
    output logic           memToReg,
    output logic           aluSrc,
    output logic           aOp2,
    output logic           addrOp,
    output logic           writeDataOp,
    output logic           wdOp2,
    output logic           spWrite,
    output logic           spWrite2,
    output logic [3:0]     aluOp,
    output logic [3:0]     spOp,
    output logic           halted,
    output logic           err,
    output logic [2:0]     state
);

    localparam int            CW        = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] C_TIMEOUT = CW'(TIMEOUT);

    state_t         state_q, state_d;
    logic [OPW-1:0] op_q, op_d;
    logic [3:0]     funct_q, funct_d;
    logic [CW-1:0]  wait_q, wait_d;

    op_class_t      w_op_class;
    logic           w_wait_cyc;
    logic           w_timeout;
    ctrl_t          w_ctl;

    always_comb begin
        case (op_q)
            OPW'(OP_R):    w_op_class = C_R;
            OPW'(OP_ADDI): w_op_class = C_ADDI;
            OPW'(OP_LW):   w_op_class = C_LW;
            OPW'(OP_SW):   w_op_class = C_SW;
            OPW'(OP_BEQ):  w_op_class = C_BEQ;
            OPW'(OP_JMP):  w_op_class = C_JMP;
            OPW'(OP_PUSH): w_op_class = C_PUSH;
            OPW'(OP_POP):  w_op_class = C_POP;
            OPW'(OP_CALL): w_op_class = C_CALL;
            OPW'(OP_RET):  w_op_class = C_RET;
            OPW'(OP_HALT): w_op_class = C_HALT;
            default:       w_op_class = C_ILL;
        endcase
    end

    // Watchdog: counts consecutive stalled cycles in FETCH/MEM. Any other
    // cycle (ready, or a different state) clears it. It saturates at
    // TIMEOUT so a disabled watchdog (TIMEOUT=0) simply sits at zero.
    always_comb begin
        w_wait_cyc = ((state_q == S_FETCH) || (state_q == S_MEM)) && !mem_ready;
        wait_d     = '0;
        if (w_wait_cyc) begin
            wait_d = (wait_q == C_TIMEOUT) ? wait_q : wait_q + 1'b1;
        end
        w_timeout = (TIMEOUT != 0) && w_wait_cyc && (wait_d == C_TIMEOUT);
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        funct_d = funct_q;
        case (state_q)
            S_FETCH: begin
                if (mem_ready) begin
                    state_d = S_DECODE;
                    op_d    = opcode;
                    funct_d = funct;
                end else if (w_timeout) begin
                    state_d = S_ERR;
                end
            end
            S_DECODE: begin
                case (w_op_class)
                    C_ILL:   state_d = S_ERR;
                    C_HALT:  state_d = S_HALT;
                    default: state_d = S_EXEC;
                endcase
            end
            S_EXEC: begin
                case (w_op_class)
                    C_R, C_ADDI:   state_d = S_WB;
                    C_BEQ, C_JMP:  state_d = S_FETCH;
                    C_LW, C_SW, C_PUSH, C_POP, C_CALL, C_RET: state_d = S_MEM;
                    default:       state_d = S_ERR;
                endcase
            end
            S_MEM: begin
                if (mem_ready) begin
                    case (w_op_class)
                        C_SW, C_PUSH, C_CALL: state_d = S_FETCH;
                        default:              state_d = S_WB;
                    endcase
                end else if (w_timeout) begin
                    state_d = S_ERR;
                end
            end
            S_WB:    state_d = S_FETCH;
            S_HALT:  state_d = S_HALT;
            S_ERR:   state_d = S_ERR;
            default: state_d = S_ERR;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_FETCH;
            op_q    <= '0;
            funct_q <= '0;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            funct_q <= funct_d;
            wait_q  <= wait_d;
        end
    end

    ctrl_decode u_decode (
        .reset     (reset),
        .state     (state_q),
        .op_class  (w_op_class),
        .funct     (funct_q),
        .zero      (zero),
        .mem_ready (mem_ready),
        .ctl       (w_ctl)
    );

    assign mem_req     = w_ctl.mem_req;
    assign irWrite     = w_ctl.ir_write;
    assign pcWrite     = w_ctl.pc_write;
    assign pcOp        = w_ctl.pc_op;
    assign branch      = w_ctl.branch;
    assign regDst      = w_ctl.reg_dst;
    assign regWrite    = w_ctl.reg_write;
    assign memRead     = w_ctl.mem_read;
    assign memWrite    = w_ctl.mem_write;
    assign memToReg    = w_ctl.mem_to_reg;
    assign aluSrc      = w_ctl.alu_src;
    assign aOp2        = w_ctl.a_op2;
    assign addrOp      = w_ctl.addr_op;
    assign writeDataOp = w_ctl.write_data_op;
    assign wdOp2       = w_ctl.wd_op2;
    assign spWrite     = w_ctl.sp_write;
    assign spWrite2    = w_ctl.sp_write2;
    assign aluOp       = w_ctl.alu_op;
    assign spOp        = w_ctl.sp_op;
    assign halted      = w_ctl.halted;
    assign err         = w_ctl.err;
    assign state       = state_q;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_ctrl_fsm.sv
`default_nettype none
// ============================================================================
//  Module   : tb_multicycle_ctrl_fsm
//  Purpose  : Directed self-checking bench for multicycle_ctrl_fsm.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_multicycle_ctrl_fsm;

    logic       clk;
    logic       reset;
    logic [5:0] opcode;
    logic [3:0] funct;
    logic       zero;
    logic       mem_ready;

    logic mem_req, irWrite, pcWrite, pcOp, branch, regDst, regWrite, memRead;
    logic memWrite, memToReg, aluSrc, aOp2, addrOp, writeDataOp, wdOp2;
    logic spWrite, spWrite2, halted, err;
    logic [3:0] aluOp, spOp;
    logic [2:0] state;

    multicycle_ctrl_fsm #(.OPW(6), .TIMEOUT(16)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .mem_req(mem_req), .irWrite(irWrite),
        .pcWrite(pcWrite), .pcOp(pcOp), .branch(branch), .regDst(regDst),
        .regWrite(regWrite), .memRead(memRead), .memWrite(memWrite),
        .memToReg(memToReg), .aluSrc(aluSrc), .aOp2(aOp2), .addrOp(addrOp),
        .writeDataOp(writeDataOp), .wdOp2(wdOp2), .spWrite(spWrite),
        .spWrite2(spWrite2), .aluOp(aluOp), .spOp(spOp), .halted(halted),
        .err(err), .state(state)
    );

    localparam logic [18:0] B_MR   = 19'd1 << 0;
    localparam logic [18:0] B_IRW  = 19'd1 << 1;
    localparam logic [18:0] B_PCW  = 19'd1 << 2;
    localparam logic [18:0] B_PCOP = 19'd1 << 3;
    localparam logic [18:0] B_BR   = 19'd1 << 4;
    localparam logic [18:0] B_RD   = 19'd1 << 5;
    localparam logic [18:0] B_RW   = 19'd1 << 6;
    localparam logic [18:0] B_MRD  = 19'd1 << 7;
    localparam logic [18:0] B_MWR  = 19'd1 << 8;
    localparam logic [18:0] B_M2R  = 19'd1 << 9;
    localparam logic [18:0] B_ASRC = 19'd1 << 10;
    localparam logic [18:0] B_AOP2 = 19'd1 << 11;
    localparam logic [18:0] B_ADDR = 19'd1 << 12;
    localparam logic [18:0] B_WDO  = 19'd1 << 13;
    localparam logic [18:0] B_WD2  = 19'd1 << 14;
    localparam logic [18:0] B_SPW  = 19'd1 << 15;
    localparam logic [18:0] B_SPW2 = 19'd1 << 16;
    localparam logic [18:0] B_HLT  = 19'd1 << 17;
    localparam logic [18:0] B_ERR  = 19'd1 << 18;

    logic [18:0] obs_sb;
    assign obs_sb = {err, halted, spWrite2, spWrite, wdOp2, writeDataOp, addrOp,
                     aOp2, aluSrc, memToReg, memWrite, memRead, regWrite, regDst,
                     branch, pcOp, pcWrite, irWrite, mem_req};

    typedef struct packed {
        logic [2:0]  st;
        logic [3:0]  alu;
        logic [3:0]  sp;
        logic [18:0] sb;
    } exp_t;

    exp_t  exp_q[$];
    string tag_q[$];
    int    checks   = 0;
    int    failures = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_out();
        exp_t  e;
        exp_t  o;
        string t;
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        o = {state, aluOp, spOp, obs_sb};
        checks++;
        assert (o === e) else begin
            failures++;
            $error("FAIL %s: observed st=%0d alu=%0d sp=%0d sb=%05h expected st=%0d alu=%0d sp=%0d sb=%05h",
                   t, o.st, o.alu, o.sp, o.sb, e.st, e.alu, e.sp, e.sb);
        end
    endtask

    // One clock cycle: drive mem_ready, queue what this cycle must show,
    // sample 1 ns after the inputs settle, then move to the next falling edge.
    task automatic cyc(input string tag, input logic mr, input logic [2:0] st,
                       input logic [18:0] sb, input logic [3:0] alu = 4'd0,
                       input logic [3:0] sp = 4'd0);
        exp_t e;
        mem_ready = mr;
        e.st  = st;
        e.alu = alu;
        e.sp  = sp;
        e.sb  = sb;
        exp_q.push_back(e);
        tag_q.push_back(tag);
        #1;
        check_out();
        @(negedge clk);
    endtask

    task automatic fetch_dec(input logic [5:0] op, input logic [3:0] fn);
        opcode = op;
        funct  = fn;
        cyc("fetch", 1'b1, 3'd0, B_MR | B_IRW | B_PCW);
        opcode = 6'h2A;
        funct  = 4'hF;
        cyc("decode", 1'b1, 3'd1, 19'd0);
    endtask

    task automatic pulse_reset(input string tag);
        reset = 1'b1;
        cyc(tag, 1'b1, 3'd0, 19'd0);
        reset = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        opcode    = 6'h00;
        funct     = 4'h0;
        zero      = 1'b0;
        mem_ready = 1'b1;
        @(negedge clk);
        cyc("reset_idle", 1'b1, 3'd0, 19'd0);
        cyc("reset_idle2", 1'b1, 3'd0, 19'd0);
        reset = 1'b0;

        // R-type, funct 2
        fetch_dec(6'h00, 4'h2);
        cyc("r_exec", 1'b1, 3'd2, 19'd0, 4'd2);
        cyc("r_wb", 1'b1, 3'd4, B_RD | B_RW);

        // ADDI
        fetch_dec(6'h01, 4'h0);
        cyc("addi_exec", 1'b1, 3'd2, B_ASRC);
        cyc("addi_wb", 1'b1, 3'd4, B_RW);

        // LW with three stalled MEM cycles
        fetch_dec(6'h02, 4'h0);
        cyc("lw_exec", 1'b1, 3'd2, B_ASRC);
        for (int i = 0; i < 3; i++) cyc("lw_mem_wait", 1'b0, 3'd3, B_MR | B_MRD);
        cyc("lw_mem_rdy", 1'b1, 3'd3, B_MR | B_MRD);
        cyc("lw_wb", 1'b1, 3'd4, B_RW | B_M2R);

        // SW
        fetch_dec(6'h03, 4'h0);
        cyc("sw_exec", 1'b1, 3'd2, B_ASRC);
        cyc("sw_mem", 1'b1, 3'd3, B_MR | B_MWR);

        // BEQ taken / not taken
        fetch_dec(6'h04, 4'h0);
        zero = 1'b1;
        cyc("beq_z1_exec", 1'b1, 3'd2, B_BR | B_PCW, 4'd1);
        fetch_dec(6'h04, 4'h0);
        zero = 1'b0;
        cyc("beq_z0_exec", 1'b1, 3'd2, B_BR, 4'd1);

        // JMP
        fetch_dec(6'h05, 4'h0);
        cyc("jmp_exec", 1'b1, 3'd2, B_PCOP | B_PCW);

        // PUSH
        fetch_dec(6'h06, 4'h0);
        cyc("push_exec", 1'b1, 3'd2, B_AOP2 | B_SPW, 4'd0, 4'd2);
        cyc("push_mem", 1'b1, 3'd3, B_MR | B_ADDR | B_MWR);

        // CALL with one stalled MEM cycle
        fetch_dec(6'h08, 4'h0);
        cyc("call_exec", 1'b1, 3'd2, B_AOP2 | B_SPW, 4'd0, 4'd2);
        cyc("call_mem_wait", 1'b0, 3'd3, B_MR | B_ADDR | B_MWR | B_WDO | B_PCOP);
        cyc("call_mem_rdy", 1'b1, 3'd3, B_MR | B_ADDR | B_MWR | B_WDO | B_PCOP | B_PCW);

        // POP
        fetch_dec(6'h07, 4'h0);
        cyc("pop_exec", 1'b1, 3'd2, B_AOP2);
        cyc("pop_mem", 1'b1, 3'd3, B_MR | B_ADDR | B_MRD);
        cyc("pop_wb", 1'b1, 3'd4, B_RW | B_M2R | B_SPW2, 4'd0, 4'd1);

        // RET
        fetch_dec(6'h09, 4'h0);
        cyc("ret_exec", 1'b1, 3'd2, B_AOP2);
        cyc("ret_mem", 1'b1, 3'd3, B_MR | B_ADDR | B_MRD);
        cyc("ret_wb", 1'b1, 3'd4, B_SPW2 | B_PCOP | B_WD2 | B_PCW, 4'd0, 4'd1);

        // SW aborted by reset while waiting in MEM
        fetch_dec(6'h03, 4'h0);
        cyc("sw2_exec", 1'b1, 3'd2, B_ASRC);
        cyc("sw2_mem_wait", 1'b0, 3'd3, B_MR | B_MWR);
        pulse_reset("sw2_reset_abort");
        cyc("post_reset_fetch", 1'b0, 3'd0, B_MR);
        cyc("post_reset_fetch_rdy", 1'b1, 3'd0, B_MR | B_IRW | B_PCW);
        pulse_reset("reset_before_ill");

        // Illegal opcode
        fetch_dec(6'h0A, 4'h0);
        cyc("ill_err", 1'b1, 3'd6, B_ERR);
        cyc("ill_err_hold", 1'b0, 3'd6, B_ERR);
        pulse_reset("reset_after_ill");

        // HALT
        fetch_dec(6'h3F, 4'h0);
        cyc("halt", 1'b1, 3'd5, B_HLT);
        cyc("halt_hold", 1'b0, 3'd5, B_HLT);
        pulse_reset("reset_after_halt");

        // Watchdog: 16 stalled FETCH cycles then ERR
        for (int i = 0; i < 16; i++) cyc("wd_fetch_wait", 1'b0, 3'd0, B_MR);
        cyc("wd_err", 1'b0, 3'd6, B_ERR);
        cyc("wd_err_hold", 1'b1, 3'd6, B_ERR);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
